// File: rtl/pg_read_flush_tracker.sv
// Counts outstanding host reads and quiesces the read path on flush. Outputs are registered and
// follow inputs by one edge; there is no backpressure, and o_tx_block gates new reads while flushing.
module pg_read_flush_tracker #(
  parameter int CNT_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TMR_WIDTH      = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush_req,
  input  logic                 i_rd_req,
  input  logic                 i_rd_cpl_last,
  input  logic                 i_err_clear,
  output logic                 o_tx_block,
  output logic                 o_sel_mmio_rsp,
  output logic                 o_read_flush_done,
  output logic [CNT_WIDTH-1:0] o_outstanding,
  output logic                 o_timeout_err,
  output logic                 o_cnt_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [TMR_WIDTH-1:0] timer_q, timer_d;
  logic                 tx_block_q, tx_block_d;
  logic                 sel_mmio_q, sel_mmio_d;
  logic                 done_q, done_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 cnt_err_q, cnt_err_d;
  logic                 cnt_evt;
  logic                 tmo_evt;

  // Saturating counter; a coincident request and completion cancel out.
  always_comb begin
    count_d = count_q;
    cnt_evt = 1'b0;
    if (i_rd_req && !i_rd_cpl_last) begin
      if (count_q == CNT_MAX) cnt_evt = 1'b1;
      else                    count_d = count_q + CNT_WIDTH'(1);
    end else if (i_rd_cpl_last && !i_rd_req) begin
      if (count_q == '0) cnt_evt = 1'b1;
      else               count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tmo_evt = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (i_flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!i_flush_req) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (count_q == '0 && !i_rd_req) begin
          state_d = DONE;
        end else if (timer_q == TMR_LAST) begin
          state_d = DONE;
          tmo_evt = 1'b1;
        end else begin
          timer_d = timer_q + TMR_WIDTH'(1);
        end
      end
      DONE: begin
        if (!i_flush_req) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    tx_block_d    = (state_d != IDLE);
    sel_mmio_d    = (state_d != IDLE);
    done_d        = (state_d == DONE);
    // A new error event takes priority over a same-cycle clear.
    timeout_err_d = tmo_evt | (timeout_err_q & ~i_err_clear);
    cnt_err_d     = cnt_evt | (cnt_err_q & ~i_err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      timer_q       <= '0;
      tx_block_q    <= 1'b0;
      sel_mmio_q    <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      tx_block_q    <= tx_block_d;
      sel_mmio_q    <= sel_mmio_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      cnt_err_q     <= cnt_err_d;
    end
  end

  assign o_tx_block        = tx_block_q;
  assign o_sel_mmio_rsp    = sel_mmio_q;
  assign o_read_flush_done = done_q;
  assign o_outstanding     = count_q;
  assign o_timeout_err     = timeout_err_q;
  assign o_cnt_err         = cnt_err_q;

endmodule

// File: tb/tb_pg_read_flush_tracker.sv
// Scoreboard bench: each driven cycle pushes the expected post-edge outputs; a monitor pops and compares.
module tb_pg_read_flush_tracker;

  localparam int CW   = 3;
  localparam int TO   = 16;
  localparam int TW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_flush_req = 1'b0;
  logic          i_rd_req = 1'b0;
  logic          i_rd_cpl_last = 1'b0;
  logic          i_err_clear = 1'b0;
  logic          o_tx_block, o_sel_mmio_rsp, o_read_flush_done, o_timeout_err, o_cnt_err;
  logic [CW-1:0] o_outstanding;

  pg_read_flush_tracker #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO), .TMR_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .i_flush_req(i_flush_req), .i_rd_req(i_rd_req),
    .i_rd_cpl_last(i_rd_cpl_last), .i_err_clear(i_err_clear), .o_tx_block(o_tx_block),
    .o_sel_mmio_rsp(o_sel_mmio_rsp), .o_read_flush_done(o_read_flush_done),
    .o_outstanding(o_outstanding), .o_timeout_err(o_timeout_err), .o_cnt_err(o_cnt_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];

  // Reference model: mode 0 idle, 1 draining, 2 done.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_tmr  = 0;
  bit m_terr = 0;
  bit m_cerr = 0;
  bit flush_lvl = 0;

  function automatic logic [7:0] outs_of(int mode, int cnt, bit terr, bit cerr);
    logic [CW-1:0] c;
    c = CW'(cnt);
    return {mode != 0, mode != 0, mode == 2, c, terr, cerr};
  endfunction

  function automatic logic [7:0] dut_outs();
    return {o_tx_block, o_sel_mmio_rsp, o_read_flush_done, o_outstanding, o_timeout_err, o_cnt_err};
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (tx,sel,done,cnt[%0d],terr,cerr)", nm, act, exp, CW);
  endtask

  function automatic void model_step(bit req, bit cpl, bit flush, bit clr);
    bit cnt_bad = 0, tmo = 0;
    int cnt = m_cnt;
    if (req && !cpl) begin
      if (m_cnt == MAXC) cnt_bad = 1; else cnt = m_cnt + 1;
    end else if (cpl && !req) begin
      if (m_cnt == 0) cnt_bad = 1; else cnt = m_cnt - 1;
    end
    if (m_mode == 0) begin
      m_tmr = 0;
      if (flush) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!flush) begin m_mode = 0; m_tmr = 0; end
      else if (m_cnt == 0 && !req) m_mode = 2;
      else if (m_tmr == TO - 1) begin m_mode = 2; tmo = 1; end
      else m_tmr++;
    end else begin
      if (!flush) begin m_mode = 0; m_tmr = 0; end
    end
    m_cnt  = cnt;
    m_terr = tmo || (m_terr && !clr);
    m_cerr = cnt_bad || (m_cerr && !clr);
  endfunction

  task automatic cyc(string nm, bit req = 0, bit cpl = 0, bit clr = 0);
    @(negedge clk);
    i_rd_req      = req;
    i_rd_cpl_last = cpl;
    i_err_clear   = clr;
    i_flush_req   = flush_lvl;
    model_step(req, cpl, flush_lvl, clr);
    exp_q.push_back(outs_of(m_mode, m_cnt, m_terr, m_cerr));
    name_q.push_back(nm);
  endtask

  task automatic idle_cycles(string nm, int n);
    for (int i = 0; i < n; i++) cyc(nm);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check(name_q.pop_front(), dut_outs(), exp_q.pop_front());
  end

  initial begin
    #12;
    check("reset_state", dut_outs(), 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Idle flush: blocking next cycle, done one cycle later, all drop together.
    idle_cycles("idle", 3);
    flush_lvl = 1; idle_cycles("idle_flush", 8);
    flush_lvl = 0; idle_cycles("idle_release", 3);

    // Normal drain of 5, completions spaced 3 cycles apart.
    for (int i = 0; i < 5; i++) cyc("load5", 1);
    flush_lvl = 1; idle_cycles("drain5_wait", 2);
    for (int i = 0; i < 5; i++) begin
      cyc("drain5_cpl", 0, 1);
      idle_cycles("drain5_gap", 2);
    end
    idle_cycles("drain5_done", 3);
    flush_lvl = 0; idle_cycles("drain5_release", 2);

    // Simultaneous request/completion, then a late request during drain.
    for (int i = 0; i < 3; i++) cyc("load3", 1);
    cyc("simul", 1, 1);
    idle_cycles("simul_hold", 1);
    flush_lvl = 1; idle_cycles("drain4_enter", 1);
    cyc("drain_inflight_req", 1);
    for (int i = 0; i < 4; i++) begin
      cyc("drain4_cpl", 0, 1);
      idle_cycles("drain4_gap", 1);
    end
    idle_cycles("drain4_done", 2);
    flush_lvl = 0; idle_cycles("drain4_release", 2);

    // Timeout with 2 outstanding; a completion after timeout; then clear.
    cyc("load2", 1); cyc("load2", 1);
    flush_lvl = 1; idle_cycles("timeout_drain", 20);
    cyc("post_tmo_cpl", 0, 1);
    idle_cycles("post_tmo", 2);
    cyc("err_clear", 0, 0, 1);
    cyc("post_tmo_cpl2", 0, 1);
    cyc("cpl_at_zero_in_done", 0, 1);
    cyc("clear_vs_set", 0, 1, 1);
    cyc("err_clear2", 0, 0, 1);
    flush_lvl = 0; idle_cycles("tmo_release", 2);

    // Saturation and underflow.
    for (int i = 0; i < 8; i++) cyc("saturate", 1);
    idle_cycles("sat_hold", 1);
    cyc("sat_clear", 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc("unload", 0, 1);
    cyc("underflow", 0, 1);
    cyc("uf_clear", 0, 0, 1);

    // Abort: flush dropped mid-drain never produces done.
    cyc("load_abort", 1); cyc("load_abort", 1);
    flush_lvl = 1; idle_cycles("abort_drain", 4);
    flush_lvl = 0; idle_cycles("abort_idle", 3);

    // Asynchronous reset in the middle of a drain.
    flush_lvl = 1; idle_cycles("pre_reset_drain", 3);
    @(negedge clk);
    i_rd_req = 0; i_rd_cpl_last = 0; i_err_clear = 0;
    #2 reset = 1'b1;
    #1 check("async_reset_mid_drain", dut_outs(), 8'h00);
    @(negedge clk);
    flush_lvl = 0; i_flush_req = 0; reset = 1'b0;
    m_mode = 0; m_cnt = 0; m_tmr = 0; m_terr = 0; m_cerr = 0;
    idle_cycles("after_reset", 2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) flush_lvl = ~flush_lvl;
      cyc("random", $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 3);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pg_read_flush_tracker.md
Name: pg_read_flush_tracker

Overview:
- Quiesces the PCIe read path of a PR-slot port before a port soft reset.
- Tracks outstanding host memory read requests from the AFU against their final completions.
- On a flush request, blocks new reads, switches TX to FIM-generated MMIO responses and waits for the count to drain (or time out).
- Sits between the PR-slot PCIe TX/RX streams and the port gasket; drives the gasket's i_sel_mmio_rsp / i_read_flush_done inputs in place of today's tie-offs.

Parameters:
- CNT_WIDTH, 10: outstanding-read counter width; saturating maximum is 2^CNT_WIDTH-1.
- TIMEOUT_CYCLES, 65536: maximum cycles spent in DRAIN before forced completion. Must be ≥2.
- TMR_WIDTH, 17: timer width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  port clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_flush_req  in  1  level from the port reset FSM; high requests quiesce, low releases.
- i_rd_req  in  1  one-cycle pulse per accepted TX memory-read request (SOP handshake).
- i_rd_cpl_last  in  1  one-cycle pulse per final completion of a read (byte count exhausted).
- i_err_clear  in  1  pulse; clears sticky error flags.
- o_tx_block  out  1  gate for new AFU read requests.
- o_sel_mmio_rsp  out  1  selects FIM-generated MMIO responses on TX.
- o_read_flush_done  out  1  outstanding reads drained or timed out.
- o_outstanding  out  CNT_WIDTH  current outstanding-read count.
- o_timeout_err  out  1  sticky; a drain ended by timeout.
- o_cnt_err  out  1  sticky; counter underflow or saturation.

Behaviour:
- Reset values:
  - state IDLE; count 0; timer 0.
  - o_tx_block, o_sel_mmio_rsp, o_read_flush_done, o_timeout_err, o_cnt_err all 0.
- All outputs are registered.
- Counter runs in every state; updates one cycle after its input pulses:
  - i_rd_req only: +1.
  - i_rd_cpl_last only: −1.
  - Both in the same cycle: unchanged.
  - +1 at maximum: holds at max, sets o_cnt_err.
  - −1 at 0: holds at 0, sets o_cnt_err.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE:
    - Outputs low, timer 0.
    - i_flush_req high at edge N → DRAIN at N+1.
  - DRAIN:
    - o_tx_block=1, o_sel_mmio_rsp=1; timer increments each cycle.
    - Requests still arriving (in-flight handshakes) are counted.
    - If count_q==0 and no i_rd_req this cycle → DONE next edge.
    - Else if timer==TIMEOUT_CYCLES-1 → DONE next edge and set o_timeout_err.
    - If i_flush_req drops → IDLE next edge; no done and no error.
  - DONE:
    - o_tx_block=1, o_sel_mmio_rsp=1, o_read_flush_done=1.
    - Held while i_flush_req is high.
    - i_flush_req low → IDLE next edge; all three outputs drop with it and the timer clears.
- Minimum latency with zero outstanding: flush_req high at edge N → DRAIN N+1 → done high from N+2.
- Completions arriving in DONE after a timeout:
  - decrement the counter normally, or set o_cnt_err if the count is 0;
  - the FSM does not change state.
- Same-cycle i_err_clear and a new error event: the set wins.
- Asynchronous reset mid-drain: immediate return to reset values; the count is lost. Upstream must reset the AFU together with this block.

Test Plan:
- Idle flush: count 0, raise i_flush_req at cycle 10 → o_tx_block/o_sel_mmio_rsp high at 11, o_read_flush_done high at 12; drop req at 20 → all low at 21.
- Normal drain: 5 i_rd_req pulses, then flush; 5 i_rd_cpl_last spaced 3 cycles apart → done asserts 2 cycles after the 5th completion; o_outstanding walks 5→0; no errors.
- Simultaneous events: with count 3, i_rd_req and i_rd_cpl_last in the same cycle → count stays 3; one request arriving during DRAIN → count 4, done delayed until 4 completions.
- Timeout: TIMEOUT_CYCLES=16, count 2, no completions → DONE after 16 DRAIN cycles; o_timeout_err=1; a later completion drops count to 1; i_err_clear clears the flag.
- Counter bounds: CNT_WIDTH=3, 8 requests → count holds 7, o_cnt_err=1; from count 0, a completion pulse → count 0, o_cnt_err=1.
- Reset/abort: assert reset mid-DRAIN → outputs 0 immediately, count 0; separately, drop i_flush_req in DRAIN → IDLE next cycle, done never asserted.
